// File: rtl/risc_ctrl.sv
// Eight-phase fetch/execute sequencer for the 8-bit accumulator machine.
// Phase state is registered; all strobes decode combinationally from it.
module risc_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   input  logic       go,
   output logic [2:0] phase,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       halt,
   output logic       ld_pc,
   output logic       data_e,
   output logic       ld_ac,
   output logic       wr
);

   typedef enum logic [2:0] {
      INST_ADDR, INST_FETCH, INST_LOAD, IDLE,
      OP_ADDR, OP_FETCH, ALU_OP, STORE
   } phase_e;

   typedef enum logic [2:0] {
      OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP
   } opcode_e;

   phase_e state, state_nxt;
   logic   entry;      // first cycle of the current phase visit
   logic   halted;
   logic   alu_op, is_sto, is_jmp, is_hlt, is_skz;

   always_comb begin
      alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
               (opcode == OP_XOR) || (opcode == OP_LDA);
      is_sto = (opcode == OP_STO);
      is_jmp = (opcode == OP_JMP);
      is_hlt = (opcode == OP_HLT);
      is_skz = (opcode == OP_SKZ);
   end

   // NOTE: every output gets a default before the case so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      halt   = 1'b0;
      ld_pc  = 1'b0;
      data_e = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      unique case (state)
         INST_ADDR:  sel = 1'b1;
         INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
         INST_LOAD:  begin sel = 1'b1; rd = 1'b1; ld_ir = entry; end
         IDLE:       begin sel = 1'b1; rd = 1'b1; end
         OP_ADDR:    begin inc_pc = entry; halt = halted; end
         OP_FETCH:   rd = alu_op;
         ALU_OP: begin
            rd     = alu_op;
            inc_pc = entry && is_skz && zero;
            ld_pc  = entry && is_jmp;
            data_e = is_sto;
         end
         STORE: begin
            rd     = alu_op;
            ld_ac  = entry && alu_op;
            ld_pc  = entry && is_jmp;
            data_e = is_sto;
            wr     = is_sto;
         end
         default: ;
      endcase
   end

   // Memory stalls and halt hold the phase; otherwise advance with 7->0 wrap.
   always_comb begin
      state_nxt = phase_e'(state + 3'd1);
      unique case (state)
         INST_FETCH: if (!mem_ready) state_nxt = state;
         OP_ADDR: begin
            if (halted)
               state_nxt = go ? OP_FETCH : OP_ADDR;
            else if (entry && is_hlt)
               state_nxt = OP_ADDR;
         end
         OP_FETCH:   if (alu_op && !mem_ready) state_nxt = state;
         STORE:      if (is_sto && !mem_ready) state_nxt = state;
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= INST_ADDR;
         entry  <= 1'b1;
         halted <= 1'b0;
      end else begin
         state <= state_nxt;
         entry <= (state_nxt != state);
         if (state == OP_ADDR && entry && is_hlt && !halted)
            halted <= 1'b1;
         else if (halted && go)
            halted <= 1'b0;
      end
   end

   assign phase = state;

endmodule

// File: tb/tb_risc_ctrl.sv
// Scoreboard bench for risc_ctrl: a cycle model predicts phase and strobes,
// predictions are queued on drive and compared when the DUT settles.
module tb_risc_ctrl;

   localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND_ = 3'd3,
                          XOR_ = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;
   localparam logic [11:0] RESET_VEC = {3'd0, 9'b1_0000_0000};

   logic       clk = 1'b0;
   logic       rst, zero, mem_ready, go;
   logic [2:0] opcode, phase;
   logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
   logic [11:0] dut_vec;

   risc_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .go(go), .phase(phase), .sel(sel), .rd(rd),
      .ld_ir(ld_ir), .inc_pc(inc_pc), .halt(halt), .ld_pc(ld_pc),
      .data_e(data_e), .ld_ac(ld_ac), .wr(wr)
   );

   always #5 clk = ~clk;

   assign dut_vec = {phase, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};

   int vectors = 0;
   int miscompares = 0;
   logic [11:0] sb_q[$];

   int m_phase;
   bit m_first, m_halted;
   int n_inc, n_ldir, n_ldac, n_ldpc, n_wr;

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_alu(input logic [2:0] op);
      return (op == ADD) || (op == AND_) || (op == XOR_) || (op == LDA);
   endfunction

   function automatic logic [11:0] model_out(input logic [2:0] op, input logic z);
      logic s, r, li, ip, h, lp, de, la, w;
      s  = (m_phase <= 3);
      r  = (m_phase >= 1 && m_phase <= 3) || (m_phase >= 5 && is_alu(op));
      li = (m_phase == 2) && m_first;
      ip = m_first && ((m_phase == 4) || (m_phase == 6 && op == SKZ && z));
      h  = (m_phase == 4) && m_halted;
      lp = m_first && (m_phase == 6 || m_phase == 7) && (op == JMP);
      de = (m_phase == 6 || m_phase == 7) && (op == STO);
      la = m_first && (m_phase == 7) && is_alu(op);
      w  = (m_phase == 7) && (op == STO);
      return {m_phase[2:0], s, r, li, ip, h, lp, de, la, w};
   endfunction

   task automatic model_reset();
      m_phase  = 0;
      m_first  = 1'b1;
      m_halted = 1'b0;
   endtask

   task automatic model_step(input logic [2:0] op, input logic mr, input logic g);
      int nxt;
      nxt = (m_phase + 1) % 8;
      if (m_phase == 1 && !mr) nxt = 1;
      if (m_phase == 5 && is_alu(op) && !mr) nxt = 5;
      if (m_phase == 7 && op == STO && !mr) nxt = 7;
      if (m_phase == 4) begin
         if (m_halted) begin
            nxt = g ? 5 : 4;
            if (g) m_halted = 1'b0;
         end else if (m_first && op == HLT) begin
            nxt = 4;
            m_halted = 1'b1;
         end
      end
      m_first = (nxt != m_phase);
      m_phase = nxt;
   endtask

   // One clock: drive, predict, compare away from the edge, then step.
   task automatic cycle(input string name, input logic [2:0] op, input logic z,
                        input logic mr, input logic g);
      logic [11:0] exp_vec;
      opcode = op; zero = z; mem_ready = mr; go = g;
      sb_q.push_back(model_out(op, z));
      #1;
      exp_vec = sb_q.pop_front();
      check($sformatf("%s ph%0d", name, m_phase), int'(dut_vec), int'(exp_vec));
      n_inc  += int'(inc_pc);
      n_ldir += int'(ld_ir);
      n_ldac += int'(ld_ac);
      n_ldpc += int'(ld_pc);
      n_wr   += int'(wr);
      model_step(op, mr, g);
      @(negedge clk);
   endtask

   task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                            input int st_ph, input int st_n, input int halt_wait,
                            input int go_ph, output int cycles);
      int stalled, halted_cnt;
      logic mr, g;
      cycles = 0; stalled = 0; halted_cnt = 0;
      n_inc = 0; n_ldir = 0; n_ldac = 0; n_ldpc = 0; n_wr = 0;
      do begin
         mr = 1'b1;
         if (m_phase == st_ph && stalled < st_n) begin
            mr = 1'b0;
            stalled++;
         end
         g = 1'b0;
         if (m_halted) begin
            g = (halted_cnt == halt_wait);
            halted_cnt++;
         end else if (m_phase == go_ph) begin
            g = 1'b1;
         end
         cycle(name, op, z, mr, g);
         cycles++;
      end while (m_phase != 0 && cycles < 100);
   endtask

   task automatic async_reset(input string name);
      rst = 1'b1;
      #1;
      check({name, " async"}, int'(dut_vec), int'(RESET_VEC));
      model_reset();
      @(negedge clk);
      check({name, " held"}, int'(dut_vec), int'(RESET_VEC));
      rst = 1'b0; go = 1'b0;
   endtask

   initial begin
      int cyc;
      rst = 1'b1; opcode = ADD; zero = 1'b0; mem_ready = 1'b1; go = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check("reset", int'(dut_vec), int'(RESET_VEC));
      rst = 1'b0;

      // Reset in the middle of phase 5, then a clean ADD
      for (int i = 0; i < 5; i++) cycle("add_pre", ADD, 1'b0, 1'b1, 1'b0);
      async_reset("rst_ph5");
      run_instr("add", ADD, 1'b0, -1, 0, 0, -1, cyc);
      check("add cycles", cyc, 8);
      check("add ld_ir", n_ldir, 1);
      check("add ld_ac", n_ldac, 1);

      run_instr("skz_z1", SKZ, 1'b1, -1, 0, 0, -1, cyc);
      check("skz_z1 inc_pc", n_inc, 2);
      run_instr("skz_z0", SKZ, 1'b0, -1, 0, 0, -1, cyc);
      check("skz_z0 inc_pc", n_inc, 1);

      run_instr("sto", STO, 1'b0, 7, 3, 0, -1, cyc);
      check("sto cycles", cyc, 11);
      check("sto wr", n_wr, 4);

      run_instr("lda", LDA, 1'b1, 1, 2, 0, -1, cyc);
      check("lda cycles", cyc, 10);
      check("lda ld_ac", n_ldac, 1);

      run_instr("hlt", HLT, 1'b0, -1, 0, 20, -1, cyc);
      check("hlt cycles", cyc, 29);
      check("hlt inc_pc", n_inc, 1);

      run_instr("jmp", JMP, 1'b0, -1, 0, 0, 4, cyc);
      check("jmp cycles", cyc, 8);
      check("jmp ld_pc", n_ldpc, 2);
      check("jmp ld_ac", n_ldac, 0);

      // rst and go together while halted: reset must win
      for (int i = 0; i < 6; i++) cycle("hlt_pre", HLT, 1'b0, 1'b1, 1'b0);
      check("halted before rst", int'(halt), 1);
      go = 1'b1;
      async_reset("rst_go");
      run_instr("add2", ADD, 1'b0, 5, 1, 0, -1, cyc);
      check("add2 cycles", cyc, 9);

      // Mixed opcodes with random zero flags, stall points and halt lengths
      for (int i = 0; i < 24; i++) begin
         logic [2:0] op;
         int sp;
         op = 3'(i % 8);
         sp = (i % 3 == 0) ? 1 : ((i % 3 == 1) ? 5 : 7);
         run_instr("mix", op, 1'($urandom_range(0, 1)), sp,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 7)), cyc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
